ibex_rf_write_arbiter: RTL and testbench
========================================

Name: ibex_rf_write_arbiter

Overview:
- Sits directly upstream of the register file write port (W1). Merges two writeback sources onto that single port: EX-stage results and late LSU load responses.
- EX writes that lose arbitration are buffered in a small in-order queue.
- Provides operand-forwarding lookups so ID reads see values that are still queued or in flight.
- Outputs drive the register file's waddr_a_i / wdata_a_i / we_a_i directly.

Parameters:
- DataWidth, 32, width of write data and forwarded data.
- Depth, 2, EX write queue entries (≥1).
- RV32E, 0, when 1 any write address with bit 4 set is discarded.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ex_we_i  in  1  EX write request valid
- ex_waddr_i  in  5  EX destination register
- ex_wdata_i  in  DataWidth  EX result
- ex_ready_o  out  1  EX write accepted this cycle (queue not full)
- lsu_rvalid_i  in  1  load response valid (no backpressure)
- lsu_waddr_i  in  5  load destination register
- lsu_wdata_i  in  DataWidth  load data
- queue_empty_o  out  1  no EX writes pending in queue
- rf_we_o  out  1  to register file we_a_i
- rf_waddr_o  out  5  to register file waddr_a_i
- rf_wdata_o  out  DataWidth  to register file wdata_a_i
- fwd_raddr_a_i  in  5  forwarding lookup address A
- fwd_hit_a_o  out  1  pending write to fwd_raddr_a_i exists
- fwd_rdata_a_o  out  DataWidth  youngest pending value for A
- fwd_raddr_b_i  in  5  forwarding lookup address B
- fwd_hit_b_o  out  1  as A
- fwd_rdata_b_o  out  DataWidth  as A

Behaviour:
Reset:
- Queue empty.
- rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
- ex_ready_o=1, queue_empty_o=1.

Registered outputs:
- rf_* outputs are registered.
- A write selected in cycle N appears on rf_* in cycle N+1 and is committed by the register file at the end of N+1.

Input filtering:
- A write to x0 counts as accepted and is dropped: it is never queued or output.
- When RV32E=1, a write with address bit 4 set is likewise accepted and dropped.

Handshake:
- ex_ready_o = !full (combinational from state only).
- An EX write transfers when ex_we_i && ex_ready_o.
- EX must hold the request while ex_ready_o=0.

Per-cycle selection, in priority order:
1. lsu_rvalid_i: select the LSU write. A transferring EX write is enqueued.
2. Else, queue non-empty: select and pop the queue head. A transferring EX write is enqueued in the same cycle; simultaneous push and pop is legal when full, but ex_ready_o still reads 0 when full.
3. Else, EX write transferring: bypass directly to the rf_* register without enqueuing.
4. Else: rf_we_o=0 next cycle. rf_waddr_o and rf_wdata_o hold their previous values.

Queue:
- Circular buffer with wrapping pointers and an occupancy counter in 0..Depth.
- Overflow is impossible by construction.
- Pop on empty never occurs.

Ordering contract:
- Upstream issues no load while queue_empty_o=0. LSU writes are therefore always older than queued EX writes, so LSU priority preserves program order.
- queue_empty_o is combinational from the occupancy count.

Forwarding (combinational):
- Search order, youngest first: queue entries from tail down to head, then the rf_* output register (only if rf_we_o=1).
- The first address match wins. hit=1, rdata=matched data.
- Lookup address 0 always gives hit=0, rdata=0.
- No match gives hit=0, rdata=0.
- Writes arriving in the current cycle (ex_*, lsu_*) are not forwarded.

Reset mid-operation:
- Asynchronous reset discards all queued writes immediately.
- rf_we_o drops to 0 asynchronously.

Test Plan:
1. Bypass: ex_we=1, addr=5, data=0xA5A5A5A5, no LSU -> next cycle rf_we=1, waddr=5, wdata=0xA5A5A5A5; queue_empty stays 1.
2. Conflict and drain: same cycle lsu_rvalid (addr=3, data=0x11) and EX (addr=7, data=0x22) -> cycle+1 rf writes x3=0x11; cycle+2 rf writes x7=0x22; queue_empty is 0 during cycle+1, then 1.
3. Full/backpressure (Depth=2): LSU valid for 3 cycles, EX requesting every cycle -> ex_ready_o=0 on the 3rd cycle; the request is held and accepted once the first pop occurs; all EX writes reach rf_* in order with no loss.
4. Forwarding priority: queue holds x9=0x1 (older) and x9=0x2 (newer), and rf_* holds x9=0x0 -> fwd_raddr_a=9 gives hit=1, rdata=0x2; fwd_raddr_b=0 gives hit=0.
5. x0 / RV32E filtering: EX write to x0 -> ex_ready=1 and no rf_we. With RV32E=1, EX write to x17 -> dropped, and a forwarding lookup for 17 gives hit=0.
6. Reset mid-drain: queue holds 2 entries, assert rst_ni=0 mid-cycle -> rf_we_o=0 immediately; after release queue_empty=1, ex_ready=1, and no stale writes are emitted.

Source files
------------

// File: rtl/ibex_rf_write_arbiter.sv
// Write-port arbiter for the register file: merges LSU load responses and EX results,
// buffers EX writes that lose arbitration, and forwards pending values to operand reads.
module ibex_rf_write_arbiter #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2,
  parameter bit          RV32E     = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_rvalid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 queue_empty_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [4:0]           fwd_raddr_a_i,
  output logic                 fwd_hit_a_o,
  output logic [DataWidth-1:0] fwd_rdata_a_o,
  input  logic [4:0]           fwd_raddr_b_i,
  output logic                 fwd_hit_b_o,
  output logic [DataWidth-1:0] fwd_rdata_b_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [4:0]           q_addr [Depth];
  logic [DataWidth-1:0] q_data [Depth];
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CntW-1:0]      count_q;

  logic                 rf_we_q;
  logic [4:0]           rf_waddr_q;
  logic [DataWidth-1:0] rf_wdata_q;

  logic                 q_empty, q_full;
  logic                 ex_keep, lsu_keep;
  logic                 push, pop;
  logic                 sel_we;
  logic [4:0]           sel_addr;
  logic [DataWidth-1:0] sel_data;

  function automatic logic dropped(input logic [4:0] addr);
    return (addr == 5'd0) || (RV32E && addr[4]);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign q_empty       = (count_q == '0);
  assign q_full        = (count_q == CntW'(Depth));
  assign ex_ready_o    = !q_full;
  assign queue_empty_o = q_empty;

  // Filtered writes are still accepted by the handshake; they simply never go anywhere.
  assign ex_keep  = ex_we_i && ex_ready_o && !dropped(ex_waddr_i);
  assign lsu_keep = lsu_rvalid_i && !dropped(lsu_waddr_i);

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = rf_waddr_q;
    sel_data = rf_wdata_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (lsu_keep) begin
      sel_we   = 1'b1;
      sel_addr = lsu_waddr_i;
      sel_data = lsu_wdata_i;
      push     = ex_keep;
    end else if (!q_empty) begin
      sel_we   = 1'b1;
      sel_addr = q_addr[head_q];
      sel_data = q_data[head_q];
      pop      = 1'b1;
      push     = ex_keep;
    end else if (ex_keep) begin
      sel_we   = 1'b1;
      sel_addr = ex_waddr_i;
      sel_data = ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
    end else begin
      if (push) begin
        q_addr[tail_q] <= ex_waddr_i;
        q_data[tail_q] <= ex_wdata_i;
        tail_q         <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= sel_we;
      if (sel_we) begin
        rf_waddr_q <= sel_addr;
        rf_wdata_q <= sel_data;
      end
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

  // Scan oldest to youngest so later matches overwrite earlier ones: youngest wins.
  function automatic logic [DataWidth:0] fwd_lookup(input logic [4:0] raddr);
    logic                 hit;
    logic [DataWidth-1:0] data;
    int unsigned          pos;
    logic [PtrW-1:0]      idx;
    hit  = 1'b0;
    data = '0;
    if (rf_we_q && (rf_waddr_q == raddr)) begin
      hit  = 1'b1;
      data = rf_wdata_q;
    end
    for (int unsigned i = 0; i < Depth; i++) begin
      pos = 32'(head_q) + i;
      if (pos >= Depth) pos = pos - Depth;
      idx = PtrW'(pos);
      if ((i < 32'(count_q)) && (q_addr[idx] == raddr)) begin
        hit  = 1'b1;
        data = q_data[idx];
      end
    end
    if (raddr == 5'd0) begin
      hit  = 1'b0;
      data = '0;
    end
    return {hit, data};
  endfunction

  always_comb begin
    {fwd_hit_a_o, fwd_rdata_a_o} = fwd_lookup(fwd_raddr_a_i);
    {fwd_hit_b_o, fwd_rdata_b_o} = fwd_lookup(fwd_raddr_b_i);
  end

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for ibex_rf_write_arbiter: a default instance plus an RV32E instance
// sharing the same stimulus.
module tb_ibex_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_rvalid;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic [4:0]  fwd_a, fwd_b;

  logic        ex_ready, q_empty, rf_we, hit_a, hit_b;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rd_a, rd_b;

  logic        e_ex_ready, e_q_empty, e_rf_we, e_hit_a, e_hit_b;
  logic [4:0]  e_rf_waddr;
  logic [31:0] e_rf_wdata, e_rd_a, e_rd_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(ex_ready),
    .lsu_rvalid_i(lsu_rvalid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .queue_empty_o(q_empty),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .fwd_raddr_a_i(fwd_a), .fwd_hit_a_o(hit_a), .fwd_rdata_a_o(rd_a),
    .fwd_raddr_b_i(fwd_b), .fwd_hit_b_o(hit_b), .fwd_rdata_b_o(rd_b)
  );

  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b1)) u_e (
    .clk_i(clk), .rst_ni(rst_n),
    .ex_we_i(ex_we), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata), .ex_ready_o(e_ex_ready),
    .lsu_rvalid_i(lsu_rvalid), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .queue_empty_o(e_q_empty),
    .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
    .fwd_raddr_a_i(fwd_a), .fwd_hit_a_o(e_hit_a), .fwd_rdata_a_o(e_rd_a),
    .fwd_raddr_b_i(fwd_b), .fwd_hit_b_o(e_hit_b), .fwd_rdata_b_o(e_rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic ev, input logic [4:0] ea, input logic [31:0] ed);
    lsu_rvalid = lv; lsu_waddr = la; lsu_wdata = ld;
    ex_we = ev; ex_waddr = ea; ex_wdata = ed;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_wdata"}, rf_wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    fwd_a = 5'd0; fwd_b = 5'd0;
    #3;
    chk_rf("reset", 1'b0, 5'd0, 32'h0);
    chk("reset_ready", 32'(ex_ready), 32'd1);
    chk("reset_empty", 32'(q_empty), 32'd1);
    #9 rst_n = 1'b1;
    tick();

    // 1: bypass
    drive(1'b0, 5'd0, '0, 1'b1, 5'd5, 32'hA5A5A5A5);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk_rf("byp", 1'b1, 5'd5, 32'hA5A5A5A5);
    chk("byp_empty", 32'(q_empty), 32'd1);
    tick();
    chk_rf("byp_idle", 1'b0, 5'd5, 32'hA5A5A5A5);

    // 2: LSU vs EX conflict, then drain
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk_rf("cf_lsu", 1'b1, 5'd3, 32'h11);
    chk("cf_empty0", 32'(q_empty), 32'd0);
    fwd_a = 5'd7;
    #1;
    chk("cf_fwd_hit", 32'(hit_a), 32'd1);
    chk("cf_fwd_data", rd_a, 32'h22);
    tick();
    chk_rf("cf_drain", 1'b1, 5'd7, 32'h22);
    chk("cf_empty1", 32'(q_empty), 32'd1);
    tick();
    chk("cf_idle", 32'(rf_we), 32'd0);
    fwd_a = 5'd0;

    // 3: fill the queue behind three loads, EX held under backpressure
    drive(1'b1, 5'd1, 32'h100, 1'b1, 5'd10, 32'hE0);
    chk("bp_rdy0", 32'(ex_ready), 32'd1);
    tick();
    chk_rf("bp_c0", 1'b1, 5'd1, 32'h100);
    drive(1'b1, 5'd2, 32'h200, 1'b1, 5'd11, 32'hE1);
    chk("bp_rdy1", 32'(ex_ready), 32'd1);
    tick();
    chk_rf("bp_c1", 1'b1, 5'd2, 32'h200);
    drive(1'b1, 5'd4, 32'h400, 1'b1, 5'd12, 32'hE2);
    chk("bp_rdy2", 32'(ex_ready), 32'd0);
    chk("bp_full_empty", 32'(q_empty), 32'd0);
    tick();
    chk_rf("bp_c2", 1'b1, 5'd4, 32'h400);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd12, 32'hE2);
    chk("bp_rdy3", 32'(ex_ready), 32'd0);
    tick();
    chk_rf("bp_c3", 1'b1, 5'd10, 32'hE0);
    chk("bp_rdy4", 32'(ex_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk_rf("bp_c4", 1'b1, 5'd11, 32'hE1);
    tick();
    chk_rf("bp_c5", 1'b1, 5'd12, 32'hE2);
    chk("bp_empty", 32'(q_empty), 32'd1);
    tick();
    chk("bp_idle", 32'(rf_we), 32'd0);

    // 4: forwarding priority, youngest queued value wins over older entry and rf register
    drive(1'b1, 5'd20, 32'h55, 1'b1, 5'd9, 32'h1);
    tick();
    drive(1'b1, 5'd9, 32'h0, 1'b1, 5'd9, 32'h2);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk_rf("fw_rf", 1'b1, 5'd9, 32'h0);
    fwd_a = 5'd9; fwd_b = 5'd0;
    #1;
    chk("fw_hit_a", 32'(hit_a), 32'd1);
    chk("fw_data_a", rd_a, 32'h2);
    chk("fw_hit_b0", 32'(hit_b), 32'd0);
    chk("fw_data_b0", rd_b, 32'h0);
    fwd_b = 5'd20;
    #1;
    chk("fw_miss_hit", 32'(hit_b), 32'd0);
    chk("fw_miss_data", rd_b, 32'h0);
    tick();
    chk_rf("fw_pop1", 1'b1, 5'd9, 32'h1);
    chk("fw_data_a1", rd_a, 32'h2);
    tick();
    chk_rf("fw_pop2", 1'b1, 5'd9, 32'h2);
    chk("fw_rfreg_hit", 32'(hit_a), 32'd1);
    chk("fw_rfreg_data", rd_a, 32'h2);
    tick();
    chk("fw_stale_hit", 32'(hit_a), 32'd0);
    fwd_b = 5'd0;

    // 5: x0 and RV32E filtering
    drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF);
    chk("x0_ready", 32'(ex_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk("x0_no_we", 32'(rf_we), 32'd0);
    chk("x0_empty", 32'(q_empty), 32'd1);
    drive(1'b0, 5'd0, '0, 1'b1, 5'd17, 32'h77);
    chk("e_ready", 32'(e_ex_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    fwd_a = 5'd17;
    #1;
    chk("e_no_we", 32'(e_rf_we), 32'd0);
    chk("e_fwd_hit", 32'(e_hit_a), 32'd0);
    chk("e_fwd_data", e_rd_a, 32'h0);
    chk_rf("i_x17", 1'b1, 5'd17, 32'h77);
    chk("i_fwd_hit", 32'(hit_a), 32'd1);
    chk("i_fwd_data", rd_a, 32'h77);
    tick();
    fwd_a = 5'd0;

    // 6: asynchronous reset while two entries are queued
    drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
    tick();
    drive(1'b1, 5'd3, 32'hC, 1'b1, 5'd4, 32'hD);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    chk_rf("rs_pre", 1'b1, 5'd3, 32'hC);
    chk("rs_pre_full", 32'(ex_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk_rf("rs_async", 1'b0, 5'd0, 32'h0);
    chk("rs_empty", 32'(q_empty), 32'd1);
    chk("rs_ready", 32'(ex_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();
    chk("rs_post0", 32'(rf_we), 32'd0);
    tick();
    chk("rs_post1", 32'(rf_we), 32'd0);
    chk("rs_post_empty", 32'(q_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
